// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS memory stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;
    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;
endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response port of the memory stage.
// Latency: combinational wires only.
// Backpressure: memory holds off completion by keeping dmem_ready low.
interface memory_stage_if;
    logic                        dmem_req;
    logic                        dmem_we;
    logic [mips_pkg::WORD_W-1:0] dmem_addr;
    logic [mips_pkg::WORD_W-1:0] dmem_wdata;
    logic [mips_pkg::WORD_W-1:0] dmem_rdata;
    logic                        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory-access FSM (IDLE/WAIT), stall generation and saturating stall counter.
// Latency: stall_m/complete are combinational from state and dmem_ready.
// Backpressure: stall_m asserts while WAIT and dmem_ready is low.
module mem_ctrl
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_e,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              stall_m,
    output logic              complete,
    output logic [WORD_W-1:0] stall_cnt
);

    mem_state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new op enters the M-register on every non-stalled edge, so the next
    // state is always decided by the op being loaded.
    always_comb begin
        state_nxt = state;
        dmem_req  = 1'b0;
        stall_m   = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = start_e ? WAIT : IDLE;
            end
            WAIT: begin
                dmem_req = 1'b1;
                stall_m  = ~dmem_ready;
                complete = dmem_ready;
                if (dmem_ready) begin
                    state_nxt = start_e ? WAIT : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_m && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + WORD_W'(1);
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: M-register, data-memory access, W-register. MEM_ALIGN_CHECK_EN enables misalignment trapping.
// Latency: one cycle M->W for ALU ops and zero-wait memory; memory ops add one cycle per dmem_ready-low WAIT cycle.
// Backpressure: stall_m holds the execute stage while an access waits on dmem_ready.
module memory_stage
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     alu_out_e,
    input  logic [WORD_W-1:0]     write_data_e,
    input  logic [REG_ADDR_W-1:0] write_reg_e,
    input  logic                  reg_write_e,
    input  logic                  mem_to_reg_e,
    input  logic                  mem_write_e,
    input  logic                  branch_e,
    output logic                  stall_m,
    memory_stage_if.master        dmem,
    output logic                  reg_write_w,
    output logic                  mem_to_reg_w,
    output logic                  branch_w,
    output logic [REG_ADDR_W-1:0] write_reg_w,
    output logic [WORD_W-1:0]     alu_out_w,
    output logic [WORD_W-1:0]     read_data_w,
    output logic [WORD_W-1:0]     result_w,
    output logic                  addr_err_w,
    output logic [WORD_W-1:0]     stall_cnt
);

    logic [WORD_W-1:0]     alu_out_m;
    logic [WORD_W-1:0]     write_data_m;
    logic [REG_ADDR_W-1:0] write_reg_m;
    logic                  reg_write_m;
    logic                  mem_to_reg_m;
    logic                  mem_write_m;
    logic                  branch_m;
    logic                  start_e;
    logic                  misaligned_m;
    logic                  complete;

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned memory ops never start an access; they flow to W flagged.
    assign start_e        = (mem_write_e | mem_to_reg_e) && (alu_out_e[1:0] == 2'b00);
    assign misaligned_m   = (mem_write_m | mem_to_reg_m) && (alu_out_m[1:0] != 2'b00);
    assign dmem.dmem_addr = alu_out_m;
`else
    assign start_e        = mem_write_e | mem_to_reg_e;
    assign misaligned_m   = 1'b0;
    assign dmem.dmem_addr = {alu_out_m[WORD_W-1:2], 2'b00};
`endif

    mem_ctrl u_mem_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start_e    (start_e),
        .dmem_ready (dmem.dmem_ready),
        .dmem_req   (dmem.dmem_req),
        .stall_m    (stall_m),
        .complete   (complete),
        .stall_cnt  (stall_cnt)
    );

    assign dmem.dmem_we    = dmem.dmem_req & mem_write_m;
    assign dmem.dmem_wdata = write_data_m;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_out_m    <= '0;
            write_data_m <= '0;
            write_reg_m  <= '0;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
            branch_m     <= 1'b0;
        end else if (!stall_m) begin
            alu_out_m    <= alu_out_e;
            write_data_m <= write_data_e;
            write_reg_m  <= write_reg_e;
            reg_write_m  <= reg_write_e;
            mem_to_reg_m <= mem_to_reg_e;
            mem_write_m  <= mem_write_e;
            branch_m     <= branch_e;
        end
    end

    // While stalled, W sees a bubble: side-effecting controls cleared, data held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            branch_w     <= 1'b0;
            write_reg_w  <= '0;
            alu_out_w    <= '0;
            addr_err_w   <= 1'b0;
        end else if (stall_m) begin
            reg_write_w  <= 1'b0;
            branch_w     <= 1'b0;
            addr_err_w   <= 1'b0;
        end else begin
            reg_write_w  <= reg_write_m & ~misaligned_m;
            mem_to_reg_w <= mem_to_reg_m;
            branch_w     <= branch_m;
            write_reg_w  <= write_reg_m;
            alu_out_w    <= alu_out_m;
            addr_err_w   <= misaligned_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_w <= '0;
        end else if (complete && mem_to_reg_m) begin
            read_data_w <= dmem.dmem_rdata;
        end
    end

    assign result_w = mem_to_reg_w ? read_data_w : alu_out_w;

endmodule
